mpu_spi_responder: RTL and testbench

// SPI-slave model of the MPU-6500 register interface, the peer of our SPI-master sensor driver.

---
 rtl/mpu_spi_responder.sv | 119 +++++++++++
 tb/tb_mpu_spi_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mpu_spi_responder.sv
// mpu_spi_responder: SPI mode-0 slave emulating the MPU-6500 register file (snapshot, PWR_MGMT_1, WHO_AM_I)
module mpu_spi_responder #(
  parameter logic [7:0] WHO_AM_I_VAL  = 8'h70,
  parameter logic [7:0] PWR_RESET_VAL = 8'h40,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [15:0] accel_x,
  input  logic [15:0] accel_y,
  input  logic [15:0] accel_z,
  input  logic [15:0] temp,
  input  logic [15:0] gyro_x,
  input  logic [15:0] gyro_y,
  input  logic [15:0] gyro_z,
  output logic        sleep,
  output logic        reg_wr,
  output logic [6:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        xfer_done,
  output logic        frame_err
);
  typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic sclk_p_q, cs_p_q, done_q;
  logic [6:0] rx_q, addr_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] tx_q, pwr_q, rx_byte, rd_data;
  logic [111:0] snap_q, snap_sh;
  logic [3:0] snap_idx;
  logic sclk_s, cs_s, mosi_s, active, sclk_rise, sclk_fall, cs_rise, cs_fall, byte_end, in_snap;
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign active    = ~cs_s && state_q != IDLE;
  assign sclk_rise = active & sclk_s & ~sclk_p_q;
  assign sclk_fall = active & ~sclk_s & sclk_p_q;
  assign cs_fall   = cs_p_q & ~cs_s;
  assign cs_rise   = ~cs_p_q & cs_s;
  assign byte_end  = sclk_rise && bit_cnt_q == 3'd7;
  assign rx_byte   = {rx_q, mosi_s};
  assign sleep     = pwr_q[6];
  assign spi_miso  = tx_q[7] & (state_q != IDLE);
  // Snapshot bytes are big-endian words, so byte k sits at the top after shifting left by 8k.
  assign snap_idx  = 4'(addr_q - 7'h3B);
  assign in_snap   = addr_q >= 7'h3B && addr_q <= 7'h48;
  assign snap_sh   = snap_q << {snap_idx, 3'b000};
  always_comb begin
    rd_data = in_snap ? snap_sh[111:104] : addr_q == 7'h6B ? pwr_q :
              addr_q == 7'h75 ? WHO_AM_I_VAL : 8'h00;
    state_d = cs_rise ? IDLE : cs_fall ? CMD :
              (state_q == CMD && byte_end) ? (rx_byte[7] ? RD : WR) : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q      <= '0;
      cs_q        <= '1;
      mosi_q      <= '0;
      sclk_p_q    <= 1'b0;
      cs_p_q      <= 1'b1;
      state_q     <= IDLE;
      done_q      <= 1'b0;
      rx_q        <= '0;
      addr_q      <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      pwr_q       <= PWR_RESET_VAL & 8'h7F;
      snap_q      <= '0;
      reg_wr      <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      xfer_done   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
      cs_q      <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_q    <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_p_q  <= sclk_s;
      cs_p_q    <= cs_s;
      state_q   <= state_d;
      reg_wr    <= 1'b0;
      xfer_done <= cs_rise;
      frame_err <= cs_rise && bit_cnt_q != 3'd0;
      if (cs_fall) begin
        if (!pwr_q[6]) snap_q <= {accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z};
        bit_cnt_q <= '0;
        tx_q      <= '0;
        done_q    <= 1'b0;
      end
      if (sclk_rise) begin
        rx_q      <= rx_byte[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (byte_end) begin
          done_q <= 1'b1;
          if (state_q == CMD) addr_q <= rx_byte[6:0];
          else if (state_q == WR) begin
            reg_wr      <= 1'b1;
            reg_wr_addr <= addr_q;
            reg_wr_data <= rx_byte;
            addr_q      <= addr_q + 7'd1;
            if (addr_q == 7'h6B) pwr_q <= rx_byte[7] ? (PWR_RESET_VAL & 8'h7F) : {1'b0, rx_byte[6:0]};
          end
        end
      end
      if (sclk_fall) begin
        done_q <= 1'b0;
        if (done_q && state_q == RD) begin
          tx_q   <= rd_data;
          addr_q <= addr_q + 7'd1;
        end else tx_q <= {tx_q[6:0], 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_mpu_spi_responder.sv
// tb_mpu_spi_responder: directed SPI-master bench for mpu_spi_responder with hand-computed expectations
module tb_mpu_spi_responder;
  localparam int H = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0, spi_miso;
  logic [15:0] accel_x = '0, accel_y = '0, accel_z = '0, temp = '0, gyro_x = '0, gyro_y = '0, gyro_z = '0;
  logic sleep, reg_wr, xfer_done, frame_err;
  logic [6:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  int n_tests = 0, n_fail = 0;
  int wr_cnt = 0, xd_cnt = 0, fe_cnt = 0;
  logic [6:0] wr_a = '0;
  logic [7:0] wr_d = '0;
  logic [7:0] r0, r1, r2;
  logic [7:0] exp3 [14] = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hEE,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h01};
  int wr0, xd0, fe0;
  logic b;

  mpu_spi_responder dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp(temp),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z), .sleep(sleep), .reg_wr(reg_wr),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .xfer_done(xfer_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_wr) begin
      wr_cnt <= wr_cnt + 1;
      wr_a   <= reg_wr_addr;
      wr_d   <= reg_wr_data;
    end
    if (xfer_done) xd_cnt <= xd_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic tb, output logic rb);
    spi_mosi = tb;
    wait_clk(H);
    rb = spi_miso;
    spi_sclk = 1'b1;
    wait_clk(H);
    spi_sclk = 1'b0;
  endtask

  task automatic xbyte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) bit_xfer(tx[i], rx[i]);
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_hi();
    wait_clk(H);
    spi_cs_n = 1'b1;
    wait_clk(2 * H);
  endtask

  task automatic frame2(input logic [7:0] a, input logic [7:0] d, output logic [7:0] q0, output logic [7:0] q1);
    cs_lo();
    xbyte(a, q0);
    xbyte(d, q1);
    cs_hi();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_miso", spi_miso, 1'b0);
    chk("rst_sleep", sleep, 1'b1);
    chk("rst_reg_wr", reg_wr, 1'b0);
    chk("rst_xfer_done", xfer_done, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_wr_addr", reg_wr_addr, 7'h00);
    chk("rst_wr_data", reg_wr_data, 8'h00);

    frame2(8'h6B, 8'h00, r0, r1);
    chk("t1_wr_cnt", wr_cnt, 1);
    chk("t1_wr_addr", wr_a, 7'h6B);
    chk("t1_wr_data", wr_d, 8'h00);
    chk("t1_sleep", sleep, 1'b0);
    chk("t1_xfer_done", xd_cnt, 1);
    chk("t1_frame_err", fe_cnt, 0);

    frame2(8'hF5, 8'h00, r0, r1);
    chk("t2_cmd_byte", r0, 8'h00);
    chk("t2_whoami", r1, 8'h70);
    chk("t2_no_write", wr_cnt, 1);

    accel_x = 16'h1234; temp = 16'hFFEE; gyro_z = 16'h8001;
    cs_lo();
    xbyte(8'hBB, r0);
    chk("t3_cmd_byte", r0, 8'h00);
    for (int i = 0; i < 14; i++) begin
      if (i == 3) begin
        accel_x = 16'hAAAA; accel_y = 16'h5555; temp = 16'h0000; gyro_z = 16'h7777;
      end
      xbyte(8'h00, r1);
      chk($sformatf("t3_snap_%0d", i), r1, exp3[i]);
    end
    cs_hi();

    do_reset();
    accel_x = 16'hA5A5; accel_y = 16'h1111; accel_z = 16'h2222; temp = 16'h3333;
    gyro_x = 16'h4444; gyro_y = 16'h5555; gyro_z = 16'h6666;
    cs_lo();
    xbyte(8'hBB, r0);
    for (int i = 0; i < 14; i++) begin
      xbyte(8'h00, r1);
      chk($sformatf("t4_sleep_snap_%0d", i), r1, 8'h00);
    end
    cs_hi();

    cs_lo();
    xbyte(8'hFF, r0);
    xbyte(8'h00, r1);
    xbyte(8'h00, r2);
    cs_hi();
    chk("t5_reg7f", r1, 8'h00);
    chk("t5_wrap_reg00", r2, 8'h00);
    cs_lo();
    xbyte(8'hF4, r0);
    xbyte(8'h00, r1);
    xbyte(8'h00, r2);
    cs_hi();
    chk("t5_reg74", r1, 8'h00);
    chk("t5_incr_whoami", r2, 8'h70);
    frame2(8'h6B, 8'h01, r0, r1);
    chk("t5_sleep_clear", sleep, 1'b0);
    frame2(8'hEB, 8'h00, r0, r1);
    chk("t5_pwr_rd", r1, 8'h01);
    frame2(8'h6B, 8'h80, r0, r1);
    chk("t5_rst_wr_data", wr_d, 8'h80);
    chk("t5_rst_sleep", sleep, 1'b1);
    frame2(8'hEB, 8'h00, r0, r1);
    chk("t5_pwr_reload", r1, 8'h40);

    wr0 = wr_cnt; xd0 = xd_cnt; fe0 = fe_cnt;
    cs_lo();
    xbyte(8'h6B, r0);
    for (int i = 0; i < 5; i++) bit_xfer(1'b0, b);
    cs_hi();
    chk("t6_frame_err", fe_cnt - fe0, 1);
    chk("t6_xfer_done", xd_cnt - xd0, 1);
    chk("t6_no_write", wr_cnt - wr0, 0);
    chk("t6_sleep_kept", sleep, 1'b1);

    frame2(8'h6B, 8'h00, r0, r1);
    chk("t6_awake", sleep, 1'b0);
    accel_x = 16'hFFFF;
    xd0 = xd_cnt;
    cs_lo();
    xbyte(8'hBB, r0);
    for (int i = 0; i < 3; i++) bit_xfer(1'b0, b);
    wait_clk(H);
    chk("t6_miso_mid", spi_miso, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_miso", spi_miso, 1'b0);
    chk("t6_rst_sleep", sleep, 1'b1);
    spi_cs_n = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(2 * H);
    chk("t6_no_xfer_after_rst", xd_cnt - xd0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
